// File: rtl/rv_pkg.sv
// Shared RV32I R-type encoding constants, ALU control codes and loader state type.
package rv_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  // ALU control codes, same encoding as the control unit
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {StIdle, StActive, StDone} loader_state_e;

endpackage

// File: rtl/rtype_encoder.sv
// Combinational ALU-request to RV32I R-type word encoder; flags codes with no R-type mapping.
module rtype_encoder
  import rv_pkg::*;
(
  input  logic [3:0]  alu,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] word,
  output logic        legal
);

  logic [2:0] funct3;
  logic [6:0] funct7;

  // Unmapped codes fall back to the add encoding and report illegal.
  always_comb begin
    funct3 = F3_ADD_SUB;
    funct7 = F7_BASE;
    legal  = 1'b1;
    case (alu)
      ALU_ADD: funct3 = F3_ADD_SUB;
      ALU_SUB: funct7 = F7_ALT;
      ALU_SLL: funct3 = F3_SLL;
      ALU_SLT: funct3 = F3_SLT;
      ALU_XOR: funct3 = F3_XOR;
      ALU_SRL: funct3 = F3_SRL;
      ALU_OR:  funct3 = F3_OR;
      ALU_AND: funct3 = F3_AND;
      default: legal  = 1'b0;
    endcase
  end

  assign word = {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};

endmodule

// File: rtl/rtype_program_loader.sv
// Encodes ALU requests into R-type words and streams them into instruction memory.
// Optional RTYPE_LOADER_ILLEGAL_CHECK_EN: drop codes 1000-1111 and raise sticky err.
module rtype_program_loader
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_alu,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef RTYPE_LOADER_ILLEGAL_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  localparam logic [ADDR_W:0]   LastCnt  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        write;

  rtype_encoder u_encoder (
    .alu   (req_alu),
    .rd    (req_rd),
    .rs1   (req_rs1),
    .rs2   (req_rs2),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign accept = req_valid & (state_q == StActive);
  assign write  = accept & (enc_legal | ~CheckEn);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StActive;
          count_d = '0;
          ptr_d   = BaseAddr;
          err_d   = 1'b0;
        end
      end
      StActive: begin
        if (write) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = enc_word;
          ptr_d   = ptr_q + 1'b1;  // wraps modulo 2**ADDR_W
          count_d = count_q + 1'b1;
        end else if (accept) begin
          err_d = 1'b1;
        end
        if (finish || (write && count_q == LastCnt)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      ptr_q   <= BaseAddr;
      addr_q  <= BaseAddr;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == StActive);
  assign done       = (state_q == StDone);
  assign req_ready  = busy;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule
